// File: rtl/i2c_pkg.sv
// Shared definitions for the byte-level I2C master and its sequencing controller.
package i2c_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StRsA,
    StStA,
    StStB,
    StBit,
    StHold,
    StSpA,
    StSpB,
    StSpC
  } i2c_mst_state_t;

  function automatic int unsigned qtr_cycles(input int unsigned sys_hz,
                                             input int unsigned i2c_hz);
    return sys_hz / (32'd4 * i2c_hz);
  endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-SCL-period strobe generator; reload realigns the phase to a command accept.
module i2c_tick_gen #(
  parameter int unsigned Qtr = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic reload,
  output logic tick
);

  localparam int unsigned W = (Qtr > 1) ? $clog2(Qtr) : 1;
  localparam logic [W-1:0] Last = W'(Qtr - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == Last);

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (reload || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/i2c_master_byte.sv
// Write-only I2C master: executes START / data / repeated-START / STOP commands on
// open-drain SCL/SDA and reports completion and NACK to the sequencing controller.
module i2c_master_byte
  import i2c_pkg::*;
#(
  parameter int unsigned SYS_CLK_HZ = 100_000_000,
  parameter int unsigned I2C_HZ     = 100_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i2c_en,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] tx_data,
  output logic       ready,
  output logic       tx_done,
  output logic       ack_err,
  output logic       bus_busy,
  output logic       scl,
  inout  wire        sda
);

  localparam int unsigned Qtr = qtr_cycles(SYS_CLK_HZ, I2C_HZ);

  if (Qtr < 2) begin : g_qtr_check
    $error("i2c_master_byte: SYS_CLK_HZ / (4 * I2C_HZ) must be at least 2");
  end

  i2c_mst_state_t state_q, state_d;
  logic [1:0] qtr_q, qtr_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic       ack_err_q, ack_err_d;
  logic       load_q, load_d;
  logic       tx_done_q, tx_done_d;
  logic       accept, tick, scl_oe, sda_oe, sda_in, cur_bit;

  i2c_tick_gen #(
    .Qtr(Qtr)
  ) u_tick_gen (
    .clk    (clk),
    .reset_n(reset_n),
    .reload (accept),
    .tick   (tick)
  );

  assign sda_in   = sda;
  assign scl      = scl_oe ? 1'b0 : 1'bz;
  assign sda      = sda_oe ? 1'b0 : 1'bz;
  assign ready    = (state_q == StIdle) || (state_q == StHold);
  assign bus_busy = (state_q != StIdle);
  assign tx_done  = tx_done_q;
  assign ack_err  = ack_err_q;

  // tx_data arrives one cycle after accept; a data byte from HOLD is already in q0 then.
  assign cur_bit = load_q ? tx_data[7] : shreg_q[7];

  always_comb begin
    state_d   = state_q;
    qtr_d     = qtr_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    ack_err_d = ack_err_q;
    load_d    = 1'b0;
    tx_done_d = 1'b0;
    accept    = 1'b0;
    scl_oe    = 1'b0;
    sda_oe    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i2c_en && start) begin
          accept    = 1'b1;
          ack_err_d = 1'b0;
          load_d    = 1'b1;
          state_d   = StStA;
        end
      end
      StRsA: begin
        scl_oe = 1'b1;
        if (tick) state_d = StStA;
      end
      StStA: begin
        if (tick) state_d = StStB;
      end
      StStB: begin
        sda_oe = 1'b1;
        if (tick) begin
          state_d   = StBit;
          qtr_d     = 2'd0;
          bit_cnt_d = 4'd0;
        end
      end
      StBit: begin
        scl_oe = (qtr_q == 2'd0) || (qtr_q == 2'd3);
        sda_oe = (bit_cnt_q != 4'd8) && !cur_bit;
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          if ((qtr_q == 2'd1) && (bit_cnt_q == 4'd8) && sda_in) ack_err_d = 1'b1;
          if (qtr_q == 2'd3) begin
            if (bit_cnt_q == 4'd8) begin
              state_d   = StHold;
              tx_done_d = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
              shreg_d   = {shreg_q[6:0], 1'b0};
            end
          end
        end
      end
      StHold: begin
        scl_oe = 1'b1;
        sda_oe = 1'b1;
        if (i2c_en) begin
          accept = 1'b1;
          if (stop) begin
            state_d = StSpA;
          end else if (start) begin
            state_d   = StRsA;
            ack_err_d = 1'b0;
            load_d    = 1'b1;
          end else begin
            state_d   = StBit;
            qtr_d     = 2'd0;
            bit_cnt_d = 4'd0;
            load_d    = 1'b1;
          end
        end
      end
      StSpA: begin
        scl_oe = 1'b1;
        sda_oe = 1'b1;
        if (tick) state_d = StSpB;
      end
      StSpB: begin
        sda_oe = 1'b1;
        if (tick) state_d = StSpC;
      end
      StSpC: begin
        if (tick) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (load_q) shreg_d = tx_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      qtr_q     <= 2'd0;
      bit_cnt_q <= 4'd0;
      shreg_q   <= 8'd0;
      ack_err_q <= 1'b0;
      load_q    <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      qtr_q     <= qtr_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      ack_err_q <= ack_err_d;
      load_q    <= load_d;
      tx_done_q <= tx_done_d;
    end
  end

endmodule
